iter_div: RTL

- Multi-cycle radix-2 integer divider; the counterpart of the pipelined multiplier in the execute stage. Together they cover RV32M div/divu/rem/remu.
- Accepts one operation via a start pulse and iterates one quotient bit per cycle. Presents a registered result with a done pulse.
- Honours the pipeline stall so that it freezes in lock-step with the rest of the core.

---
 rtl/iter_div.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/iter_div.sv
// Radix-2 restoring integer divider (RV32M div/divu/rem/remu), one quotient bit per cycle.
// Define DIV_FAST_SPECIAL_EN to finish divide-by-zero, overflow and |divisor|==1 in one cycle.
module iter_div #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            start,
    input  logic            is_signed,
    input  logic            want_rem,
    input  logic [XLEN-1:0] opA,
    input  logic [XLEN-1:0] opB,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int unsigned     CntW    = $clog2(XLEN);
    localparam logic [CntW-1:0] CntLast = CntW'(XLEN - 1);
    localparam logic [XLEN-1:0] MinNeg  = {1'b1, {(XLEN - 1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] dvd_q, dvd_d;
    logic [XLEN-1:0] dvs_q, dvs_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            want_rem_q, want_rem_d;
    logic            q_neg_q, q_neg_d;
    logic            r_neg_q, r_neg_d;
    logic            div0_q, div0_d;
    logic            ovf_q, ovf_d;

    logic            accept;
    logic            a_neg, b_neg, div0_in, ovf_in;
    logic [XLEN-1:0] a_mag, b_mag;
    logic [XLEN:0]   partial, diff;
    logic            no_borrow;
    logic [XLEN-1:0] rem_nx, dvd_nx, q_fix, r_fix, fin_q, fin_r, finish_val;

    // Operand preparation for the accept edge
    always_comb begin
        accept  = start && !stall && (state_q == StIdle || state_q == StDone);
        a_neg   = is_signed && opA[XLEN-1];
        b_neg   = is_signed && opB[XLEN-1];
        a_mag   = a_neg ? -opA : opA;
        b_mag   = b_neg ? -opB : opB;
        div0_in = (opB == '0);
        ovf_in  = is_signed && (opA == MinNeg) && (opB == '1);
    end

    // One restoring step plus the sign/special fix-up applied on the final step
    always_comb begin
        partial   = {rem_q, dvd_q[XLEN-1]};
        diff      = partial - {1'b0, dvs_q};
        no_borrow = !diff[XLEN];
        rem_nx    = no_borrow ? diff[XLEN-1:0] : partial[XLEN-1:0];
        dvd_nx    = {dvd_q[XLEN-2:0], no_borrow};
        q_fix     = q_neg_q ? -dvd_nx : dvd_nx;
        // With a zero divisor the remainder path just shifts the dividend magnitude through,
        // so the sign fix-up restores the original dividend.
        r_fix     = r_neg_q ? -rem_nx : rem_nx;
        fin_q     = div0_q ? '1 : (ovf_q ? MinNeg : q_fix);
        fin_r     = ovf_q ? '0 : r_fix;
        finish_val = want_rem_q ? fin_r : fin_q;
    end

`ifdef DIV_FAST_SPECIAL_EN
    logic            special_in;
    logic [XLEN-1:0] fast_q, fast_r, fast_val;

    always_comb begin
        special_in = div0_in || ovf_in || (b_mag == XLEN'(1));
        fast_q     = div0_in ? '1 : ((a_neg ^ b_neg) ? -a_mag : a_mag);
        fast_r     = div0_in ? opA : '0;
        fast_val   = want_rem ? fast_r : fast_q;
    end
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        dvd_d      = dvd_q;
        dvs_d      = dvs_q;
        result_d   = result_q;
        want_rem_d = want_rem_q;
        q_neg_d    = q_neg_q;
        r_neg_d    = r_neg_q;
        div0_d     = div0_q;
        ovf_d      = ovf_q;

        if (!stall) begin
            unique case (state_q)
                StCalc: begin
                    rem_d = rem_nx;
                    dvd_d = dvd_nx;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CntLast) begin
                        state_d  = StDone;
                        result_d = finish_val;
                    end
                end
                StDone:  state_d = StIdle;
                default: ;
            endcase
        end

        if (accept) begin
            state_d    = StCalc;
            cnt_d      = '0;
            rem_d      = '0;
            dvd_d      = a_mag;
            dvs_d      = b_mag;
            want_rem_d = want_rem;
            q_neg_d    = a_neg ^ b_neg;
            r_neg_d    = a_neg;
            div0_d     = div0_in;
            ovf_d      = ovf_in;
`ifdef DIV_FAST_SPECIAL_EN
            if (special_in) begin
                state_d  = StDone;
                result_d = fast_val;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            rem_q      <= '0;
            dvd_q      <= '0;
            dvs_q      <= '0;
            result_q   <= '0;
            want_rem_q <= 1'b0;
            q_neg_q    <= 1'b0;
            r_neg_q    <= 1'b0;
            div0_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            dvd_q      <= dvd_d;
            dvs_q      <= dvs_d;
            result_q   <= result_d;
            want_rem_q <= want_rem_d;
            q_neg_q    <= q_neg_d;
            r_neg_q    <= r_neg_d;
            div0_q     <= div0_d;
            ovf_q      <= ovf_d;
        end
    end

    assign busy   = (state_q == StCalc);
    assign done   = (state_q == StDone);
    assign result = result_q;

endmodule
